// File: rtl/agu_fetch_unit_if.sv
// Bus bundle between the fetch unit, the AGU, the SRAM and the PE-array consumer.
// Handshakes: a beat on the AGU side moves when agu_valid is high. The AGU is
// never stalled, and it is paced only by agu_read_req credits. A beat on the
// output side moves on the clock edge where out_valid & out_ready are both high.
// Once out_valid is raised, out_data/out_id/out_addr hold until that edge.
interface agu_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  agu_read_req;
    logic [ADDR_WIDTH-1:0] agu_addr;
    logic [1:0]            agu_id;
    logic                  agu_valid;
    logic                  agu_is_null;

    logic                  sram_en;
    logic [1:0]            sram_sel;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_rdata;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_id;
    logic [ADDR_WIDTH-1:0] out_addr;

    // Fetch-unit side.
    modport master (
        output agu_read_req,
        input  agu_addr, agu_id, agu_valid, agu_is_null,
        output sram_en, sram_sel, sram_addr,
        input  sram_rdata,
        output out_valid, out_data, out_id, out_addr,
        input  out_ready
    );

    // Environment side: AGU, SRAM and consumer.
    modport slave (
        input  agu_read_req,
        output agu_addr, agu_id, agu_valid, agu_is_null,
        input  sram_en, sram_sel, sram_addr,
        output sram_rdata,
        input  out_valid, out_data, out_id, out_addr,
        output out_ready
    );
endinterface

// File: rtl/agu_fetch_unit.sv
// AGU fetch unit. Every AGU beat enters a MEM_LAT-deep pipeline. Act/ker beats
// read SRAM. Null, out and illegal beats carry zero data. All beats land in an
// ordered output FIFO. AGU requests are credit-limited, so the FIFO cannot overflow.
module agu_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    agu_fetch_unit_if.master bus,
    output logic             busy,
    output logic             err_ovf,
    output logic             err_bad_id
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int UW   = CW + 2;
    localparam int LAST = MEM_LAT - 1;

    logic [CW-1:0]         pend_q, pend_d;
    logic                  pipe_vld_q  [MEM_LAT];
    logic [1:0]            pipe_id_q   [MEM_LAT];
    logic [ADDR_WIDTH-1:0] pipe_addr_q [MEM_LAT];
    logic                  pipe_null_q [MEM_LAT];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [1:0]            fifo_id_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_ovf_q, err_ovf_d, err_bad_id_q, err_bad_id_d;

    logic [UW-1:0]         pipe_cnt, used;
    logic                  read_req, accept, issue, push, pop, full, wr_en, pend_dec;
    logic [DATA_WIDTH-1:0] push_data;

    // Count occupied pipeline stages so in-flight beats consume credits.
    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < MEM_LAT; i++) pipe_cnt = pipe_cnt + UW'(pipe_vld_q[i]);
    end

    assign used     = UW'(cnt_q) + UW'(pend_q) + pipe_cnt;
    assign read_req = enable & (used < UW'(FIFO_DEPTH)) & ~rst;
    assign accept   = bus.agu_valid & ~rst;
    assign issue    = accept & ~bus.agu_is_null & ~bus.agu_id[1];
    assign pend_dec = bus.agu_valid & (pend_q != '0);

    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign pop       = (cnt_q != '0) & bus.out_ready;
    assign push      = pipe_vld_q[LAST];
    assign wr_en     = push & (~full | pop);
    assign push_data = (~pipe_null_q[LAST] & ~pipe_id_q[LAST][1]) ? bus.sram_rdata : '0;

    // Next-state for the credit counter, FIFO bookkeeping and sticky errors.
    always_comb begin
        pend_d = pend_q;
        if (read_req & ~pend_dec)      pend_d = pend_q + CW'(1);
        else if (~read_req & pend_dec) pend_d = pend_q - CW'(1);

        cnt_d = cnt_q;
        if (wr_en & ~pop)      cnt_d = cnt_q + CW'(1);
        else if (~wr_en & pop) cnt_d = cnt_q - CW'(1);

        wr_ptr_d     = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        err_ovf_d    = err_ovf_q | (push & full & ~pop);
        err_bad_id_d = err_bad_id_q | (accept & (bus.agu_id == 2'b11));
    end

    // Control state register; reset drops every in-flight beat and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_ovf_q    <= 1'b0;
            err_bad_id_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_ovf_q    <= err_ovf_d;
            err_bad_id_q <= err_bad_id_d;
        end
    end

    // Pipeline valid bits; these align each beat with its SRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) pipe_vld_q[i] <= 1'b0;
        end else begin
            pipe_vld_q[0] <= accept;
            for (int i = 1; i < MEM_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
        end
    end

    // Pipeline payload; it is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        pipe_id_q[0]   <= bus.agu_id;
        pipe_addr_q[0] <= bus.agu_addr;
        pipe_null_q[0] <= bus.agu_is_null;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_id_q[i]   <= pipe_id_q[i-1];
            pipe_addr_q[i] <= pipe_addr_q[i-1];
            pipe_null_q[i] <= pipe_null_q[i-1];
        end
    end

    // FIFO storage; the count and pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_id_q[wr_ptr_q]   <= pipe_id_q[LAST];
            fifo_addr_q[wr_ptr_q] <= pipe_addr_q[LAST];
        end
    end

    assign bus.agu_read_req = read_req;
    assign bus.sram_en      = issue;
    assign bus.sram_sel     = issue ? bus.agu_id : 2'b00;
    assign bus.sram_addr    = issue ? bus.agu_addr : '0;

    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_data  = bus.out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.out_id    = bus.out_valid ? fifo_id_q[rd_ptr_q] : 2'b00;
    assign bus.out_addr  = bus.out_valid ? fifo_addr_q[rd_ptr_q] : '0;

    assign busy       = (used != '0);
    assign err_ovf    = err_ovf_q;
    assign err_bad_id = err_bad_id_q;
endmodule
